bsg_mem_1rw_sync_mask_write_byte_arb: RTL and testbench

BSG_MEM_1RW_SYNC_MASK_WRITE_BYTE_ARB -- requirements
Module: bsg_mem_1rw_sync_mask_write_byte_arb

---
 rtl/bsg_mem_1rw_sync_mask_write_byte_arb.sv | 210 +++++++++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_byte_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_arb.sv
// bsg_mem_1rw_sync_mask_write_byte_arb
//
// Arbitrates num_req_p requesters onto a single 1rw synchronous
// byte-masked memory port. At most one request is accepted per cycle.
// In IDLE, grants rotate round-robin starting after the last winner.
// A winner that raises lock_i keeps exclusive ownership (LOCKED) until it
// completes an access with lock_i low, or until it idles with lock_i low.
// A read granted in cycle N returns its data in cycle N+1, together with
// a one-hot response strobe for the requester that issued it.
//
// Optional build macro:
//   BSG_MEM_1RW_ARB_WRITE_ACK_EN - when defined, granted writes also return a
//   response strobe one cycle after the grant. When undefined, only reads
//   produce responses.

module bsg_mem_1rw_sync_mask_write_byte_arb #(
  parameter int num_req_p = 2,
  parameter int width_p   = 32,
  parameter int els_p     = 1024,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,

  input  logic [num_req_p-1:0]                 v_i,
  input  logic [num_req_p-1:0]                 w_i,
  input  logic [num_req_p-1:0]                 lock_i,
  input  logic [num_req_p*addr_width_lp-1:0]   addr_i,
  input  logic [num_req_p*width_p-1:0]         data_i,
  input  logic [num_req_p*mask_width_lp-1:0]   mask_i,
  output logic [num_req_p-1:0]                 yumi_o,

  output logic [num_req_p-1:0]                 resp_v_o,
  output logic [width_p-1:0]                   resp_data_o,

  output logic                                 mem_v_o,
  output logic                                 mem_w_o,
  output logic [addr_width_lp-1:0]             mem_addr_o,
  output logic [width_p-1:0]                   mem_data_o,
  output logic [mask_width_lp-1:0]             mem_w_mask_o,
  input  logic [width_p-1:0]                   mem_data_i
);

  localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  localparam logic [0:0] state_idle_lc   = 1'b0;
  localparam logic [0:0] state_locked_lc = 1'b1;

  localparam logic [idx_width_lp-1:0] last_reset_lc = idx_width_lp'(num_req_p - 1);

  // State registers and their next-state values
  logic [0:0]              state_q,  state_d;
  logic [idx_width_lp-1:0] last_q,   last_d;
  logic [idx_width_lp-1:0] owner_q,  owner_d;
  logic [num_req_p-1:0]    resp_v_q, resp_v_d;

  // Combinational arbitration results
  logic                     rr_found_s;
  logic [idx_width_lp-1:0]  rr_idx_s;
  logic                     grant_v_s;
  logic [idx_width_lp-1:0]  win_idx_s;
  logic [num_req_p-1:0]     yumi_s;
  logic                     win_w_s;
  logic                     win_lock_s;
  logic [addr_width_lp-1:0] win_addr_s;
  logic [width_p-1:0]       win_data_s;
  logic [mask_width_lp-1:0] win_mask_s;
  logic                     owner_v_s;
  logic                     owner_lock_s;
  logic                     resp_en_s;

  // Owner's request and lock lines, used to decide when a lock lapses
  assign owner_v_s    = v_i[owner_q];
  assign owner_lock_s = lock_i[owner_q];

  // Round-robin search: first valid requester above last_q, else first valid at or below it
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int j = 0; j < num_req_p; j++) begin
      rr_idx_s   = (!rr_found_s && v_i[j] && (j > int'(last_q))) ? idx_width_lp'(j) : rr_idx_s;
      rr_found_s = rr_found_s | (v_i[j] && (j > int'(last_q)));
    end
    for (int j = 0; j < num_req_p; j++) begin
      rr_idx_s   = (!rr_found_s && v_i[j] && (j <= int'(last_q))) ? idx_width_lp'(j) : rr_idx_s;
      rr_found_s = rr_found_s | (v_i[j] && (j <= int'(last_q)));
    end
  end

  // Pick the winner: round-robin when idle, only the owner while locked; nothing in reset
  always_comb begin
    grant_v_s = 1'b0;
    win_idx_s = '0;
    case (state_q)
      state_idle_lc: begin
        grant_v_s = rr_found_s;
        win_idx_s = rr_idx_s;
      end
      state_locked_lc: begin
        grant_v_s = owner_v_s;
        win_idx_s = owner_q;
      end
      default: begin
        grant_v_s = 1'b0;
        win_idx_s = '0;
      end
    endcase
    grant_v_s = grant_v_s & reset_n_i;
  end

  // Decode the winner into the one-hot accept strobe and steer its request fields
  always_comb begin
    yumi_s     = '0;
    win_w_s    = 1'b0;
    win_lock_s = 1'b0;
    win_addr_s = '0;
    win_data_s = '0;
    win_mask_s = '0;
    for (int j = 0; j < num_req_p; j++) begin
      if (win_idx_s == idx_width_lp'(j)) begin
        yumi_s[j]  = grant_v_s;
        win_w_s    = w_i[j];
        win_lock_s = lock_i[j];
        win_addr_s = addr_i[j*addr_width_lp +: addr_width_lp];
        win_data_s = data_i[j*width_p +: width_p];
        win_mask_s = mask_i[j*mask_width_lp +: mask_width_lp];
      end else begin
        yumi_s[j]  = 1'b0;
      end
    end
  end

`ifdef BSG_MEM_1RW_ARB_WRITE_ACK_EN
  // Every granted access, read or write, is acknowledged
  assign resp_en_s = 1'b1;
`else
  // Only reads return a response
  assign resp_en_s = ~win_w_s;
`endif

  // Next-state logic for the lock FSM, round-robin pointer and response pipeline
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    resp_v_d = '0;

    if (grant_v_s) begin
      last_d = win_idx_s;
    end else begin
      last_d = last_q;
    end

    case (state_q)
      state_idle_lc: begin
        if (grant_v_s && win_lock_s) begin
          state_d = state_locked_lc;
          owner_d = win_idx_s;
        end else begin
          state_d = state_idle_lc;
        end
      end
      state_locked_lc: begin
        if (grant_v_s && !win_lock_s) begin
          state_d = state_idle_lc;
        end else if (!owner_v_s && !owner_lock_s) begin
          state_d = state_idle_lc;
        end else begin
          state_d = state_locked_lc;
        end
      end
      default: begin
        state_d = state_idle_lc;
      end
    endcase

    if (resp_en_s) begin
      resp_v_d = yumi_s;
    end else begin
      resp_v_d = '0;
    end
  end

  // Arbiter state; reset drops any in-flight response and restores requester 0 priority
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= state_idle_lc;
      last_q   <= last_reset_lc;
      owner_q  <= '0;
      resp_v_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      resp_v_q <= resp_v_d;
    end
  end

  assign yumi_o       = yumi_s;
  assign mem_v_o      = |yumi_s;
  assign mem_w_o      = win_w_s;
  assign mem_addr_o   = win_addr_s;
  assign mem_data_o   = win_data_s;
  assign mem_w_mask_o = win_mask_s;

  assign resp_v_o     = resp_v_q;
  assign resp_data_o  = mem_data_i;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_arb.sv
// Bench for bsg_mem_1rw_sync_mask_write_byte_arb: directed vectors drive a
// two-requester instance backed by a byte-masked sync memory model; expected
// responses go into a scoreboard queue that a negedge monitor drains. A second,
// four-requester instance exercises the round-robin rotation.
// Honours BSG_MEM_1RW_ARB_WRITE_ACK_EN for the expected write responses.

module tb_bsg_mem_1rw_sync_mask_write_byte_arb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected responses
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- two-requester DUT ----------------
  logic [1:0]  v_i, w_i, lock_i, yumi_o, resp_v_o;
  logic [19:0] addr_i;
  logic [63:0] data_i;
  logic [7:0]  mask_i;
  logic [31:0] resp_data_o, mem_data_o, mem_rdata;
  logic        mem_v_o, mem_w_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_w_mask_o;

  bsg_mem_1rw_sync_mask_write_byte_arb #(.num_req_p(2), .width_p(32), .els_p(1024)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .w_i(w_i), .lock_i(lock_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
    .yumi_o(yumi_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_rdata)
  );

  // ---------------- four-requester DUT ----------------
  logic [3:0]   v4, w4, lock4, yumi4, resp_v4, mask_unused4;
  logic [15:0]  addr4, mask4;
  logic [127:0] data4;
  logic [31:0]  resp_data4, mem_data4, mem_rdata4;
  logic         mem_v4, mem_w4;
  logic [3:0]   mem_addr4;

  bsg_mem_1rw_sync_mask_write_byte_arb #(.num_req_p(4), .width_p(32), .els_p(16)) u_dut4 (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v4), .w_i(w4), .lock_i(lock4), .addr_i(addr4), .data_i(data4), .mask_i(mask4),
    .yumi_o(yumi4), .resp_v_o(resp_v4), .resp_data_o(resp_data4),
    .mem_v_o(mem_v4), .mem_w_o(mem_w4), .mem_addr_o(mem_addr4), .mem_data_o(mem_data4),
    .mem_w_mask_o(mask_unused4), .mem_data_i(mem_rdata4)
  );

  // ---------------- memory model: 1rw sync, byte-masked writes ----------------
  logic [31:0] mem [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem_rdata  = 32'h0;
    mem_rdata4 = 32'h0;
  end

  // Memory port: apply masked writes, register read data for the next cycle
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_w_mask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr_o];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  req;
    logic [31:0] data;
    bit          chk_data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every strobe must match the queue head, and no expected response may go overdue
  always @(negedge clk) begin
    if (resp_v_o !== 2'b00) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got resp_v_o %b, expected none (cycle %0d)", resp_v_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_v", resp_v_o, mon_e.req);
        chk("resp_cycle", cyc, mon_e.due);
        if (mon_e.chk_data) chk("resp_data", resp_data_o, mon_e.data);
      end
    end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL resp_missing: got no resp_v_o, expected %b due cycle %0d", mon_e.req, mon_e.due);
    end
  end

  // One cycle of two-requester stimulus; checks the grant and queues the expected response
  task automatic issue(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] m0, input logic [3:0] m1,
                       input logic [1:0] exp_yumi, input logic [31:0] exp_rd,
                       input bit exp_resp);
    int sel;
    v_i = v; w_i = w; lock_i = lk;
    addr_i = {a1, a0}; data_i = {d1, d0}; mask_i = {m1, m0};
    #3;
    chk("yumi", yumi_o, exp_yumi);
    chk("mem_v", mem_v_o, |exp_yumi);
    if (exp_yumi != 2'b00) begin
      sel = exp_yumi[1] ? 1 : 0;
      chk("mem_w", mem_w_o, w[sel]);
      chk("mem_addr", mem_addr_o, sel ? a1 : a0);
      if (w[sel]) begin
        chk("mem_data", mem_data_o, sel ? d1 : d0);
        chk("mem_mask", mem_w_mask_o, sel ? m1 : m0);
`ifdef BSG_MEM_1RW_ARB_WRITE_ACK_EN
        sb_q.push_back('{exp_yumi, 32'h0, 1'b0, cyc + 1});
`endif
      end else if (exp_resp) begin
        sb_q.push_back('{exp_yumi, exp_rd, 1'b1, cyc + 1});
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] one4;

  initial begin
    v_i = 2'b00; w_i = 2'b00; lock_i = 2'b00; addr_i = '0; data_i = '0; mask_i = '0;
    v4 = 4'h0; w4 = 4'h0; lock4 = 4'h0; mask4 = '0; data4 = '0;
    addr4 = {4'd3, 4'd2, 4'd1, 4'd0};
    one4 = 4'b0001;

    // Reset: requests present but nothing may be accepted
    repeat (2) @(posedge clk);
    #1;
    v_i = 2'b11; v4 = 4'hF;
    #3;
    chk("rst_yumi", yumi_o, 2'b00);
    chk("rst_mem_v", mem_v_o, 1'b0);
    chk("rst_resp_v", resp_v_o, 2'b00);
    chk("rst_yumi4", yumi4, 4'h0);
    v_i = 2'b00; v4 = 4'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Contention after reset: requester 0 first, then 1
    issue(2'b11, 2'b00, 2'b00, 10'd5, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0005, 1'b1);
    issue(2'b11, 2'b00, 2'b00, 10'd5, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h1000_0009, 1'b1);

    // Masked write bytes 0 and 2, then read the merged word
    issue(2'b10, 2'b10, 2'b00, 10'd0, 10'd3, 32'h0, 32'hAABB_CCDD, 4'h0, 4'b0101, 2'b10, 32'h0, 1'b1);
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd3, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h10BB_00DD, 1'b1);

    // All-zero mask write is still granted but leaves memory untouched
    issue(2'b01, 2'b01, 2'b00, 10'd7, 10'd0, 32'h1234_5678, 32'h0, 4'h0, 4'h0, 2'b01, 32'h0, 1'b1);
    issue(2'b01, 2'b00, 2'b00, 10'd7, 10'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0007, 1'b1);
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h1000_0009, 1'b1);

    // Lock: requester 0 holds the port for three accesses while requester 1 waits
    issue(2'b11, 2'b00, 2'b01, 10'd5, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0005, 1'b1);
    issue(2'b11, 2'b00, 2'b01, 10'd6, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0006, 1'b1);
    issue(2'b11, 2'b00, 2'b01, 10'd4, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0004, 1'b1);
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 32'h0, 1'b1);
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h1000_0009, 1'b1);

    // Reset pulse right after a read grant: the response must be dropped
    issue(2'b01, 2'b00, 2'b00, 10'd2, 10'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0002, 1'b0);
    v_i = 2'b00;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_pulse_resp_v", resp_v_o, 2'b00);
    chk("rst_pulse_mem_v", mem_v_o, 1'b0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b11, 2'b00, 2'b00, 10'd8, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0008, 1'b1);
    issue(2'b11, 2'b00, 2'b00, 10'd8, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h1000_0009, 1'b1);

    // Lock released by a granted owner access with lock low
    issue(2'b01, 2'b00, 2'b01, 10'd1, 10'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0001, 1'b1);
    issue(2'b11, 2'b00, 2'b00, 10'd1, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 32'h1000_0001, 1'b1);
    issue(2'b11, 2'b00, 2'b00, 10'd1, 10'd9, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 32'h1000_0009, 1'b1);
    v_i = 2'b00;

    // Four requesters all valid: grant order 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      v4 = 4'hF;
      #3;
      chk("rr4_yumi", yumi4, one4 << (k % 4));
      chk("rr4_addr", mem_addr4, 4'(k % 4));
      @(posedge clk); #1;
    end
    v4 = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
